// File: rtl/xcr_int_ctrl.sv
// rtl/xcr_int_ctrl.sv - XCR-bus interrupt controller: 8 prioritised sources, vector generation, IN_ISP handshake
module xcr_int_ctrl #(
   parameter logic [7:0]  XCR_BASE  = 8'h10,
   parameter logic [23:0] VBASE_RST = 24'h000100,
   parameter int unsigned VEC_SHIFT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  XCRa,
   input  logic [7:0]  XCRo,
   input  logic        XCRwe,
   input  logic        XCRcs,
   output logic [7:0]  XCRi,
   input  logic [7:0]  irq_src,
   output logic        INT,
   output logic [23:0] IVEC_addr,
   input  logic        IN_ISP
);

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t      state_q;
   logic [7:0]  sync1_q, sync2_q, hist_q;
   logic [7:0]  ipend_q, ipend_d, iena_q, imode_q, icause_q;
   logic [23:0] vbase_q;
   logic [2:0]  idx_q;

   logic [7:0]  off;
   logic        in_range, wr_en;
   logic [7:0]  rise, w1c, swi, acc_clr, req;
   logic [2:0]  winner;
   logic [23:0] vec_d;

   assign off      = XCRa - XCR_BASE;
   assign in_range = (off < 8'd8);
   assign wr_en    = XCRcs & XCRwe & in_range;

   // Software clears/sets only touch edge-mode bits; level bits just mirror the synchronised input.
   assign rise    = sync2_q & ~hist_q;
   assign w1c     = (wr_en && off[2:0] == 3'd0) ? (XCRo & imode_q) : 8'h00;
   assign swi     = (wr_en && off[2:0] == 3'd7) ? (XCRo & imode_q) : 8'h00;
   assign acc_clr = (state_q == REQ && IN_ISP) ? ((8'h01 << idx_q) & imode_q) : 8'h00;
   assign ipend_d = (imode_q & ((ipend_q & ~w1c & ~acc_clr) | rise | swi))
                  | (~imode_q & sync2_q);
   assign req     = ipend_q & iena_q;

   always_comb begin
      winner = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (req[i]) winner = 3'(i);
      end
   end

   assign vec_d = vbase_q + ({21'd0, winner} << VEC_SHIFT);

   always_comb begin
      XCRi = 8'h00;
      if (XCRcs && in_range) begin
         case (off[2:0])
            3'd0:    XCRi = ipend_q;
            3'd1:    XCRi = iena_q;
            3'd2:    XCRi = imode_q;
            3'd3:    XCRi = icause_q;
            3'd4:    XCRi = vbase_q[7:0];
            3'd5:    XCRi = vbase_q[15:8];
            3'd6:    XCRi = vbase_q[23:16];
            default: XCRi = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 8'h00;
         sync2_q <= 8'h00;
         hist_q  <= 8'h00;
         ipend_q <= 8'h00;
         iena_q  <= 8'h00;
         imode_q <= 8'h00;
         vbase_q <= VBASE_RST;
      end else begin
         sync1_q <= irq_src;
         sync2_q <= sync1_q;
         hist_q  <= sync2_q;
         ipend_q <= ipend_d;
         if (wr_en) begin
            case (off[2:0])
               3'd1:    iena_q         <= XCRo;
               3'd2:    imode_q        <= XCRo;
               3'd4:    vbase_q[7:0]   <= XCRo;
               3'd5:    vbase_q[15:8]  <= XCRo;
               3'd6:    vbase_q[23:16] <= XCRo;
               default: ;
            endcase
         end
      end
   end

   // idx_q and IVEC_addr are only loaded from IDLE, so a request is never re-arbitrated while in REQ.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= 3'd0;
         INT       <= 1'b0;
         IVEC_addr <= VBASE_RST;
         icause_q  <= 8'h00;
      end else begin
         case (state_q)
            IDLE: begin
               if ((|req) && !IN_ISP) begin
                  idx_q     <= winner;
                  IVEC_addr <= vec_d;
                  INT       <= 1'b1;
                  state_q   <= REQ;
               end
            end
            REQ: begin
               if (IN_ISP) begin
                  INT      <= 1'b0;
                  icause_q <= {1'b1, 4'b0000, idx_q};
                  state_q  <= SERVICE;
               end else if (!req[idx_q]) begin
                  INT     <= 1'b0;
                  state_q <= IDLE;
               end
            end
            SERVICE: begin
               INT <= 1'b0;
               if (!IN_ISP) begin
                  icause_q[7] <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               INT     <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule
